// File: rtl/fp_seq_if.sv
// fp_seq_if: control-unit start/done handshake and F-PM status/phase/strobe bundle.
interface fp_seq_if;
   logic start, af_sf, mw_mf, dw_df, nrf, g, fic, ok, fwz, ws, fi3;
   logic _0_f, f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13;
   logic strob_fp, strob2_fp, busy, done, hang;
   modport master (
      output start, af_sf, mw_mf, dw_df, nrf, g, fic, ok, fwz, ws, fi3,
      input  _0_f, f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13,
      input  strob_fp, strob2_fp, busy, done, hang
   );
   modport slave (
      input  start, af_sf, mw_mf, dw_df, nrf, g, fic, ok, fwz, ws, fi3,
      output _0_f, f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13,
      output strob_fp, strob2_fp, busy, done, hang
   );
endinterface

// File: rtl/fp_seq.sv
// fp_seq: FPU sequencer stepping F-PM through phases F2..F13, each phase settling then
// issuing strob_fp and strob2_fp; transitions are taken on the strob2_fp cycle.
module fp_seq #(
   parameter int SETTLE_TICKS = 1,
   parameter int LOOP_LIMIT   = 80
) (
   input  logic    __clk,
   input  logic    rst_,
   fp_seq_if.slave bus
);
   typedef enum logic [12:0] {
      S_IDLE  = 13'b0000000000001,
      S_CLR   = 13'b0000000000010,
      S_F2    = 13'b0000000000100,
      S_F4    = 13'b0000000001000,
      S_F5    = 13'b0000000010000,
      S_F6    = 13'b0000000100000,
      S_F7    = 13'b0000001000000,
      S_F8    = 13'b0000010000000,
      S_F9    = 13'b0000100000000,
      S_F10   = 13'b0001000000000,
      S_F13   = 13'b0010000000000,
      S_DONE  = 13'b0100000000000,
      S_ABORT = 13'b1000000000000
   } state_t;

   localparam logic [12:0] PH_MASK = 13'b0011111111100;
   localparam logic [3:0]  T_STB   = 4'(SETTLE_TICKS);
   localparam logic [3:0]  T_STB2  = 4'(SETTLE_TICKS + 1);
   localparam logic [6:0]  LIM     = 7'(LOOP_LIMIT);

   state_t     state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic [6:0] loops_q, loops_d;
   logic       hang_q, hang_d, corr_q, corr_d, busy_q, busy_d;
   logic       strob_q, strob_d, strob2_q, strob2_d, in_ph_d;

   always_comb begin
      state_d = state_q;
      loops_d = loops_q;
      hang_d  = hang_q;
      corr_d  = corr_q;
      case (state_q)
         S_IDLE:  state_d = bus.start ? S_CLR : S_IDLE;
         S_CLR:   state_d = S_F2;
         S_F2:    if (strob2_q) state_d = bus.fi3 ? S_ABORT : bus.af_sf ? S_F5 :
                                          (bus.mw_mf || bus.dw_df) ? S_F4 : S_F8;
         S_F4:    if (strob2_q) state_d = bus.fi3 ? S_ABORT : S_F6;
         S_F5:    if (strob2_q) state_d = bus.g ? S_F8 : S_F6;
         S_F6:    if (strob2_q) state_d = S_F7;
         S_F7:    if (strob2_q) state_d = bus.fic ? S_F8 : S_F6;
         S_F8:    if (strob2_q) state_d = (bus.ok || bus.fwz) ? (bus.dw_df ? S_F9 : S_F10) : S_F8;
         S_F9:    if (strob2_q) state_d = S_F10;
         S_F10:   if (strob2_q) begin
            state_d = (bus.ws && !corr_q) ? S_F7 : S_F13;
            corr_d  = corr_q | bus.ws;
         end
         S_F13:   if (strob2_q) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      // loop guard overrides whatever the F-PM flags asked for
      if (strob2_q && (state_q inside {S_F6, S_F7, S_F8})) begin
         loops_d = loops_q + 7'd1;
         if (loops_d == LIM) begin
            hang_d  = 1'b1;
            state_d = S_DONE;
         end
      end
      if (state_q == S_IDLE && bus.start) begin
         loops_d = '0;
         hang_d  = 1'b0;
         corr_d  = 1'b0;
      end
      in_ph_d  = |(state_d & PH_MASK);
      tick_d   = (strob2_q || !(|(state_q & PH_MASK))) ? 4'd0 : tick_q + 4'd1;
      strob_d  = in_ph_d && tick_d == T_STB;
      strob2_d = in_ph_d && tick_d == T_STB2;
      busy_d   = !(state_d inside {S_IDLE, S_DONE, S_ABORT});
   end

   always_ff @(posedge __clk or negedge rst_) begin
      if (!rst_) begin
         state_q  <= S_IDLE;
         tick_q   <= '0;
         loops_q  <= '0;
         hang_q   <= 1'b0;
         corr_q   <= 1'b0;
         busy_q   <= 1'b0;
         strob_q  <= 1'b0;
         strob2_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         loops_q  <= loops_d;
         hang_q   <= hang_d;
         corr_q   <= corr_d;
         busy_q   <= busy_d;
         strob_q  <= strob_d;
         strob2_q <= strob2_d;
      end
   end

   assign bus._0_f      = state_q[1];
   assign bus.f2_       = ~state_q[2];
   assign bus.f4_       = ~state_q[3];
   assign bus.f5_       = ~state_q[4];
   assign bus.f6_       = ~state_q[5];
   assign bus.f7_       = ~state_q[6];
   assign bus.f8_       = ~state_q[7];
   assign bus.f9        = state_q[8];
   assign bus.f10_      = ~state_q[9];
   assign bus.f13       = state_q[10];
   assign bus.done      = state_q[11] | state_q[12];
   assign bus.strob_fp  = strob_q;
   assign bus.strob2_fp = strob2_q;
   assign bus.busy      = busy_q;
   assign bus.hang      = hang_q;
endmodule

// File: tb/tb_fp_seq.sv
// tb_fp_seq: phase-level reference model of the sequencer checked against fp_seq every cycle,
// driven by directed operation scripts and randomized F-PM status.
module tb_fp_seq;
   localparam int ST  = 1;
   localparam int LIM = 80;

   logic __clk = 1'b0;
   logic rst_  = 1'b0;
   fp_seq_if bus ();
   fp_seq #(.SETTLE_TICKS(ST), .LOOP_LIMIT(LIM)) dut (.__clk(__clk), .rst_(rst_), .bus(bus.slave));
   always #5 __clk = ~__clk;

   typedef struct { int ph; bit s1; bit s2; bit clr; bit bsy; bit dn; } exp_t;
   exp_t q[$];
   int   seq[$];
   int   n_chk = 0, n_fail = 0, cyc = 0, ops_done = 0;
   int   m_loops = 0, start_cyc = 0;
   bit   m_hang = 1'b0, m_corr = 1'b0;
   bit   dir_on;
   int   d_lat;
   bit   d_hang;
   int   d_seq[$];
   bit   rnd_mode;
   int   start_tok = 0, start_used = 0;
   logic [7:0] d_in;
   int   fic_after, ok_after, f7c = 0, f8c = 0;

   always @(posedge __clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [8:0] pv(input int ph);
      case (ph)
         2:       pv = 9'h100;
         4:       pv = 9'h080;
         5:       pv = 9'h040;
         6:       pv = 9'h020;
         7:       pv = 9'h010;
         8:       pv = 9'h008;
         9:       pv = 9'h004;
         10:      pv = 9'h002;
         13:      pv = 9'h001;
         default: pv = 9'h000;
      endcase
   endfunction

   task automatic push_phase(input int ph);
      seq.push_back(ph);
      for (int i = 0; i < ST; i++) q.push_back('{ph, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      q.push_back('{ph, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      q.push_back('{ph, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
   endtask

   task automatic push_done();
      q.push_back('{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
   endtask

   task automatic decide(input int ph);
      if (ph >= 6 && ph <= 8) begin
         m_loops++;
         if (m_loops == LIM) begin
            m_hang = 1'b1;
            push_done();
            return;
         end
      end
      case (ph)
         2:  if (bus.fi3) push_done(); else if (bus.af_sf) push_phase(5);
             else if (bus.mw_mf || bus.dw_df) push_phase(4); else push_phase(8);
         4:  if (bus.fi3) push_done(); else push_phase(6);
         5:  push_phase(bus.g ? 8 : 6);
         6:  push_phase(7);
         7:  push_phase(bus.fic ? 8 : 6);
         8:  if (bus.ok || bus.fwz) push_phase(bus.dw_df ? 9 : 10); else push_phase(8);
         9:  push_phase(10);
         10: if (bus.ws && !m_corr) begin m_corr = 1'b1; push_phase(7); end else push_phase(13);
         13: push_done();
         default: ;
      endcase
   endtask

   always @(negedge __clk) begin
      exp_t e;
      bit   idle;
      idle = 1'b0;
      if (!rst_ || q.size() == 0) begin
         e    = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         idle = rst_;
         if (!rst_) begin
            q.delete();
            m_hang = 1'b0;
         end
      end else e = q.pop_front();
      chk("outputs", 32'({pv(e.ph), e.s1, e.s2, e.clr, e.bsy, e.dn, m_hang}),
          32'({~bus.f2_, ~bus.f4_, ~bus.f5_, ~bus.f6_, ~bus.f7_, ~bus.f8_, bus.f9, ~bus.f10_, bus.f13,
               bus.strob_fp, bus.strob2_fp, bus._0_f, bus.busy, bus.done, bus.hang}));
      if (idle && bus.start === 1'b1) begin
         start_cyc = cyc;
         m_hang    = 1'b0;
         m_loops   = 0;
         m_corr    = 1'b0;
         seq.delete();
         q.push_back('{0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
         push_phase(2);
      end else if (e.dn) begin
         ops_done++;
         if (dir_on) begin
            chk("latency", 32'(cyc - start_cyc), 32'(d_lat));
            chk("seq_len", 32'(seq.size()), 32'(d_seq.size()));
            for (int i = 0; i < seq.size() && i < d_seq.size(); i++) chk("phase_seq", 32'(seq[i]), 32'(d_seq[i]));
            chk("hang_at_done", 32'(bus.hang), 32'(d_hang));
         end
      end else if (e.s2) decide(e.ph);
   end

   // Status responder: F-PM flags change just after each edge, per pass counts in directed mode
   always @(posedge __clk) begin
      #1;
      bus.start = (start_tok != start_used);
      if (bus.start) start_used++;
      if (rnd_mode) begin
         bus.start = bus.start | ($urandom_range(0, 7) == 0);
         {bus.af_sf, bus.mw_mf, bus.dw_df, bus.nrf, bus.g, bus.ws, bus.fwz} = 7'($urandom);
         bus.fi3 = $urandom_range(0, 19) == 0;
         bus.fic = $urandom_range(0, 2) == 0;
         bus.ok  = $urandom_range(0, 3) == 0;
      end else begin
         {bus.af_sf, bus.mw_mf, bus.dw_df, bus.nrf, bus.g, bus.ws, bus.fi3, bus.fwz} = d_in;
         if (bus._0_f) begin
            f7c = 0;
            f8c = 0;
         end
         bus.fic = 1'b0;
         bus.ok  = 1'b0;
         if (bus.strob2_fp && !bus.f7_) begin
            f7c++;
            bus.fic = f7c >= fic_after;
         end
         if (bus.strob2_fp && !bus.f8_) begin
            f8c++;
            bus.ok = f8c >= ok_after;
         end
      end
   end

   task automatic run_op();
      int n0;
      n0 = ops_done;
      start_tok++;
      for (int i = 0; i < 2000 && ops_done == n0; i++) @(posedge __clk);
      if (ops_done == n0) begin
         $display("FAIL op_timeout: no done within 2000 cycles");
         $fatal(1, "operation timeout");
      end
      repeat (3) @(posedge __clk);
   endtask

   initial begin
      int k;
      rnd_mode = 1'b0; dir_on = 1'b0; d_in = 8'h00; fic_after = 1; ok_after = 1;
      d_lat = 0; d_hang = 1'b0;
      repeat (3) @(negedge __clk);
      #2 rst_ = 1'b1;
      repeat (20) @(posedge __clk);
      dir_on = 1'b1;
      // AF, g=1, ok first F8
      d_in = 8'b1000_1000; d_seq = {2, 5, 8, 10, 13}; d_lat = 17; d_hang = 1'b0;
      run_op();
      // MF, fic on 3rd F7 pass, ok on 2nd F8 pass
      d_in = 8'b0100_0000; fic_after = 3; ok_after = 2;
      d_seq = {2, 4, 6, 7, 6, 7, 6, 7, 8, 8, 10, 13}; d_lat = 38;
      run_op();
      // DF with ws held high: single correction pass
      d_in = 8'b0010_0100; fic_after = 1; ok_after = 1;
      d_seq = {2, 4, 6, 7, 8, 9, 10, 7, 8, 9, 10, 13}; d_lat = 38;
      run_op();
      // MW with fic stuck low: loop limit abort
      d_in = 8'b0100_0000; fic_after = 1000; ok_after = 1000;
      d_seq = {2, 4};
      for (int i = 0; i < LIM / 2; i++) begin
         d_seq.push_back(6);
         d_seq.push_back(7);
      end
      d_lat = 2 + 3 * (2 + LIM); d_hang = 1'b1;
      run_op();
      // next start clears hang
      d_in = 8'b1000_1000; fic_after = 1; ok_after = 1;
      d_seq = {2, 5, 8, 10, 13}; d_lat = 17; d_hang = 1'b0;
      run_op();
      // fi3 in F2
      d_in = 8'b1000_0010; d_seq = {2}; d_lat = 5;
      run_op();
      // reset pulse during F6
      dir_on = 1'b0; d_in = 8'b0100_0000; fic_after = 1000; ok_after = 1000;
      start_tok++;
      k = 0;
      while (bus.f6_ !== 1'b0 && k < 200) begin
         @(posedge __clk);
         #1;
         k++;
      end
      if (k == 200) begin
         $display("FAIL f6_timeout: F6 never reached");
         $fatal(1, "F6 timeout");
      end
      #1 rst_ = 1'b0;
      @(negedge __clk);
      #2 rst_ = 1'b1;
      repeat (10) @(posedge __clk);
      // randomized traffic
      fic_after = 1; ok_after = 1; d_in = 8'h00;
      rnd_mode = 1'b1;
      repeat (4000) @(posedge __clk);
      rnd_mode = 1'b0;
      k = 0;
      while (q.size() != 0 && k < 2000) begin
         @(posedge __clk);
         k++;
      end
      if (k == 2000) begin
         $display("FAIL drain_timeout: operation still running");
         $fatal(1, "drain timeout");
      end
      repeat (5) @(posedge __clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
